// File: rtl/vld_rdy_buf_1w4r.sv
// Narrow-to-wide valid/ready gather buffer: packs NUM_LANES beats (lane 0 first) into one wide word.
// Optional early-completion with lane keep mask when VLD_RDY_BUF_1W4R_FLUSH_EN is defined.
module vld_rdy_buf_1w4r #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(NUM_LANES)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                slave_valid,
    output logic                                slave_ready,
    input  logic [DATA_WIDTH-1:0]               data_in,
    output logic                                master_valid,
    input  logic                                master_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]     data_out
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
    ,
    input  logic                                slave_last,
    output logic [NUM_LANES-1:0]                master_keep
`endif
);

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * NUM_LANES;
    localparam int unsigned ASM_WIDTH = DATA_WIDTH * (NUM_LANES - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_LANES - 1);

    logic [ASM_WIDTH-1:0] asm_q, asm_d;
    logic [CNT_WIDTH-1:0] lane_idx_q, lane_idx_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 out_vld_q, out_vld_d;

    logic                 last_c;
    logic                 at_last;
    logic                 wr_en;
    logic                 rd_en;
    logic                 emit;
    logic [OUT_WIDTH-1:0] asm_full;
    logic [OUT_WIDTH-1:0] word_c;

`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
    assign last_c = slave_last;
`else
    assign last_c = 1'b0;
`endif

    // Only a word-completing beat can stall, and only while the held word is not draining.
    assign at_last     = (lane_idx_q == LAST_IDX);
    assign slave_ready = (~at_last & ~last_c) | ~out_vld_q | master_ready;
    assign wr_en       = slave_valid & slave_ready;
    assign rd_en       = out_vld_q & master_ready;
    assign emit        = wr_en & (at_last | last_c);

    assign master_valid = out_vld_q;
    assign data_out     = out_q;

    // Completed word: earlier lanes from the assembly register, current beat at lane_idx, rest zero.
    always_comb begin
        asm_full = {DATA_WIDTH'(0), asm_q};
        word_c   = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (CNT_WIDTH'(i) == lane_idx_q) begin
                word_c[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end else if (CNT_WIDTH'(i) < lane_idx_q) begin
                word_c[i*DATA_WIDTH +: DATA_WIDTH] = asm_full[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        asm_d      = asm_q;
        lane_idx_d = lane_idx_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        if (rd_en) begin
            out_vld_d = 1'b0;
        end
        if (wr_en) begin
            if (emit) begin
                out_d      = word_c;
                out_vld_d  = 1'b1;
                lane_idx_d = '0;
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
                asm_d      = '0;
`endif
            end else begin
                for (int unsigned i = 0; i < NUM_LANES - 1; i++) begin
                    if (CNT_WIDTH'(i) == lane_idx_q) begin
                        asm_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
                    end
                end
                lane_idx_d = lane_idx_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            asm_q      <= '0;
            lane_idx_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            lane_idx_q <= lane_idx_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
        end
    end

`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
    logic [NUM_LANES-1:0] keep_q, keep_d;

    // Lanes 0..lane_idx of the completing word carry data.
    always_comb begin
        keep_d = keep_q;
        if (emit) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                keep_d[i] = (CNT_WIDTH'(i) <= lane_idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            keep_q <= '0;
        end else begin
            keep_q <= keep_d;
        end
    end

    assign master_keep = keep_q;
`endif

endmodule

// File: tb/tb_vld_rdy_buf_1w4r.sv
// Scoreboard bench for vld_rdy_buf_1w4r: directed vectors push expected words, a monitor pops on each transfer.
// Also exercises the VLD_RDY_BUF_1W4R_FLUSH_EN variant when that macro is defined.
module tb_vld_rdy_buf_1w4r;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned WW = DW * N;

    logic          clk = 1'b0;
    logic          rstn;
    logic          slave_valid;
    logic          slave_ready;
    logic [DW-1:0] data_in;
    logic          master_valid;
    logic          master_ready;
    logic [WW-1:0] data_out;
    logic          rdy_cmd;
    logic          rnd_rdy;
    logic          rand_rdy;
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
    logic          slave_last;
    logic [N-1:0]  master_keep;
    logic [N-1:0]  exp_keep_q[$];
`endif

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [WW-1:0] data_prev = '0;

    always #5 clk = ~clk;

    assign master_ready = rand_rdy ? rnd_rdy : rdy_cmd;

    vld_rdy_buf_1w4r dut (
        .clk          (clk),
        .rstn         (rstn),
        .slave_valid  (slave_valid),
        .slave_ready  (slave_ready),
        .data_in      (data_in),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .data_out     (data_out)
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        ,
        .slave_last   (slave_last),
        .master_keep  (master_keep)
`endif
    );

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [WW-1:0] w, input logic [N-1:0] keep);
        exp_q.push_back(w);
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        exp_keep_q.push_back(keep);
`else
        if (keep != '1) $display("note: partial keep %b ignored in this build", keep);
`endif
    endtask

    // Scoreboard monitor: pops on every accepted wide word, and checks hold stability.
    always @(negedge clk) begin
        if (hold_prev) check("hold_stable", data_out, data_prev);
        if (rstn && master_valid && master_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", data_out, 'x);
            end else begin
                check("word", data_out, exp_q.pop_front());
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
                check("keep", WW'(master_keep), WW'(exp_keep_q.pop_front()));
`endif
            end
        end
        hold_prev = rstn && master_valid && !master_ready;
        data_prev = data_out;
    end

    always begin
        @(posedge clk);
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        slave_valid = 1'b1;
        data_in     = d;
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        slave_last  = last;
`else
        if (last) $display("note: last ignored in this build");
`endif
        @(negedge clk);
        while (!slave_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", WW'(0), WW'(1));
        cyc();
        slave_valid = 1'b0;
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        slave_last  = 1'b0;
`endif
    endtask

    initial begin
        logic [WW-1:0] cur;
        int            cnt;
        time           t0;
        int            n;

        rstn        = 1'b0;
        slave_valid = 1'b0;
        data_in     = '0;
        rdy_cmd     = 1'b1;
        rnd_rdy     = 1'b0;
        rand_rdy    = 1'b0;
`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        slave_last  = 1'b0;
`endif
        repeat (3) cyc();
        @(negedge clk);
        check("reset_valid", WW'(master_valid), WW'(0));
        check("reset_data", data_out, '0);
        check("reset_ready", WW'(slave_ready), WW'(1));
        cyc();
        rstn = 1'b1;

        // 1: basic packing, lane 0 first
        push_exp(128'h00000044_00000033_00000022_00000011, 4'hF);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        check("valid_low_before_4th", WW'(master_valid), WW'(0));
        send(32'h44, 1'b0);
        @(negedge clk);
        check("latency_valid", WW'(master_valid), WW'(1));
        cyc();

        // 2: backpressure; completing beat stalls, next word loads with no bubble
        rdy_cmd = 1'b0;
        push_exp(128'h000000a4_000000a3_000000a2_000000a1, 4'hF);
        push_exp(128'h000000a8_000000a7_000000a6_000000a5, 4'hF);
        for (int i = 1; i <= 7; i++) send(DW'(32'ha0 + i), 1'b0);
        slave_valid = 1'b1;
        data_in     = 32'ha8;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", WW'(slave_ready), WW'(0));
            check("stall_valid", WW'(master_valid), WW'(1));
            cyc();
        end
        rdy_cmd = 1'b1;
        @(negedge clk);
        check("release_ready", WW'(slave_ready), WW'(1));
        cyc();
        slave_valid = 1'b0;
        @(negedge clk);
        check("no_bubble", WW'(master_valid), WW'(1));
        cyc();

        // 3: full throughput, 16 beats in 16 cycles
        for (int w = 0; w < 4; w++) begin
            push_exp({DW'(32'h100 + 4*w + 3), DW'(32'h100 + 4*w + 2),
                      DW'(32'h100 + 4*w + 1), DW'(32'h100 + 4*w)}, 4'hF);
        end
        t0 = $time;
        for (int i = 0; i < 16; i++) send(DW'(32'h100 + i), 1'b0);
        check("throughput_time", WW'($time - t0), WW'(160));
        cyc();

        // 4: reset mid-word discards partial lanes and the held word
        send(32'hee, 1'b0);
        send(32'hff, 1'b0);
        rstn = 1'b0;
        cyc();
        @(negedge clk);
        check("midreset_valid", WW'(master_valid), WW'(0));
        check("midreset_data", data_out, '0);
        rstn = 1'b1;
        cyc();
        push_exp(128'h0000000d_0000000c_0000000b_0000000a, 4'hF);
        send(32'ha, 1'b0);
        send(32'hb, 1'b0);
        send(32'hc, 1'b0);
        send(32'hd, 1'b0);
        cyc();

`ifdef VLD_RDY_BUF_1W4R_FLUSH_EN
        // 5: early completion with keep mask
        push_exp(128'h00000000_00000000_00000006_00000005, 4'b0011);
        push_exp(128'h00000024_00000023_00000022_00000021, 4'b1111);
        send(32'h5, 1'b0);
        send(32'h6, 1'b1);
        for (int i = 1; i <= 4; i++) send(DW'(32'h20 + i), 1'b0);
        cyc();
`endif

        // 6: random stalls vs packing model
        rand_rdy = 1'b1;
        cur = '0;
        cnt = 0;
        for (int b = 0; b < 10000; b++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            if ($urandom_range(0, 3) == 0) cyc();
            cur[cnt*DW +: DW] = d;
            cnt++;
            if (cnt == N) begin
                push_exp(cur, 4'hF);
                cur = '0;
                cnt = 0;
            end
            send(d, 1'b0);
        end
        rand_rdy = 1'b0;
        rdy_cmd  = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        check("drain", WW'(exp_q.size()), WW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
